// File: rtl/int_controller_pkg.sv
// int_controller_pkg: shared register offsets, FSM encoding and channel bound for int_controller
package int_controller_pkg;
  localparam int MAX_CH = 16;
  localparam logic [1:0] OFF_PEND = 2'd0;
  localparam logic [1:0] OFF_MASK = 2'd1;
  localparam logic [1:0] OFF_MODE = 2'd2;
  localparam logic [1:0] OFF_VEC  = 2'd3;
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_GAP    = 2'd2
  } state_t;
  // One bit per implemented channel; bits at or above n stay zero everywhere
  function automatic logic [MAX_CH-1:0] ch_mask(input int n);
    return (n >= MAX_CH) ? '1 : MAX_CH'((32'd1 << n) - 32'd1);
  endfunction
endpackage

// File: rtl/int_controller_prio_enc.sv
// prio_enc: lowest-index priority encoder
//   i_req : request vector, bit 0 highest priority
//   o_idx : index of the lowest set bit (0 when none set)
//   o_any : at least one request set
module prio_enc #(
  parameter int NUM_CH = 8
) (
  input  logic [NUM_CH-1:0] i_req,
  output logic [3:0]        o_idx,
  output logic              o_any
);
  // Scan downwards so the lowest set index is the last to be written
  always_comb begin
    o_idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--)
      if (i_req[i]) o_idx = 4'(i);
  end
  assign o_any = |i_req;
endmodule

// File: rtl/int_controller.sv
// int_controller: prioritised interrupt controller with IO-mapped PEND/MASK/MODE/VEC registers
//   clk, reset_n          : clock, asynchronous active-low reset
//   irq_in                : interrupt sources, bit 0 highest priority
//   IO_address, data_in   : CPU IO address and write data
//   IO_wren, IO_ren       : write strobe, read enable
//   H_en, L_en            : byte write enables for bits 15:8 / 7:0
//   IO_out                : combinational read data
//   int_rq, int_addr      : registered request and in-service vector
module int_controller
  import int_controller_pkg::*;
#(
  parameter int          NUM_CH  = 8,
  parameter logic [15:0] IO_BASE = 16'hFF00
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NUM_CH-1:0] irq_in,
  input  logic [15:0]       IO_address,
  input  logic [15:0]       data_in,
  input  logic              IO_wren,
  input  logic              IO_ren,
  input  logic              H_en,
  input  logic              L_en,
  output logic [15:0]       IO_out,
  output logic              int_rq,
  output logic [3:0]        int_addr
);
  localparam logic [15:0] CH_MASK = ch_mask(NUM_CH);
  logic [15:0] r_sync1, r_irq_s, r_irq_prev, r_pend, r_mask, r_mode;
  logic [3:0]  r_int_addr;
  state_t      r_state, w_next;
  logic [15:0] w_off, w_wmask, w_wdata, w_rise, w_clr, w_grant_clr, w_pend_next;
  logic [NUM_CH-1:0] w_req;
  logic        w_hit, w_wr_pend, w_wr_mask, w_wr_mode, w_eoi, w_any, w_grant;
  logic [3:0]  w_idx;
  // Unsigned offset from the base: anything outside 0..3 (including below base) misses
  assign w_off     = IO_address - IO_BASE;
  assign w_hit     = w_off < 16'd4;
  assign w_wr_pend = IO_wren && w_hit && w_off[1:0] == OFF_PEND;
  assign w_wr_mask = IO_wren && w_hit && w_off[1:0] == OFF_MASK;
  assign w_wr_mode = IO_wren && w_hit && w_off[1:0] == OFF_MODE;
  assign w_eoi     = IO_wren && w_hit && w_off[1:0] == OFF_VEC;
  assign w_wmask   = {{8{H_en}}, {8{L_en}}} & CH_MASK;
  assign w_wdata   = data_in & w_wmask;
  assign w_rise    = r_irq_s & ~r_irq_prev;
  assign w_req     = r_pend[NUM_CH-1:0] & r_mask[NUM_CH-1:0];
  prio_enc #(.NUM_CH(NUM_CH)) u_prio (
    .i_req(w_req),
    .o_idx(w_idx),
    .o_any(w_any)
  );
  assign w_grant     = r_state == ST_IDLE && w_any;
  // Granting an edge channel consumes its pending bit; level channels keep tracking the line
  assign w_grant_clr = w_grant ? (16'd1 << w_idx) & r_mode : '0;
  assign w_clr       = w_wr_pend ? w_wdata : '0;
  // Edge: a fresh rise overrides any clear in the same cycle. Level: mirror irq_s.
  assign w_pend_next = ((r_mode & ((r_pend & ~w_clr & ~w_grant_clr) | w_rise))
                       | (~r_mode & r_irq_s)) & CH_MASK;
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE:   w_next = w_any ? ST_ACTIVE : ST_IDLE;
      ST_ACTIVE: w_next = w_eoi ? ST_GAP : ST_ACTIVE;
      default:   w_next = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1    <= '0;
      r_irq_s    <= '0;
      r_irq_prev <= '0;
      r_pend     <= '0;
      r_mask     <= '0;
      r_mode     <= '0;
      r_state    <= ST_IDLE;
      r_int_addr <= '0;
    end else begin
      r_sync1    <= 16'(irq_in);
      r_irq_s    <= r_sync1;
      r_irq_prev <= r_irq_s;
      r_pend     <= w_pend_next;
      if (w_wr_mask) r_mask <= (r_mask & ~w_wmask) | w_wdata;
      if (w_wr_mode) r_mode <= (r_mode & ~w_wmask) | w_wdata;
      r_state    <= w_next;
      if (w_grant) r_int_addr <= w_idx;
    end
  end
  // int_rq comes straight from the state register, so reset drops it asynchronously
  assign int_rq   = r_state == ST_ACTIVE;
  assign int_addr = r_int_addr;
  always_comb begin
    IO_out = '0;
    if (reset_n && IO_ren && w_hit)
      unique case (w_off[1:0])
        OFF_PEND: IO_out = r_pend;
        OFF_MASK: IO_out = r_mask;
        OFF_MODE: IO_out = r_mode;
        default:  IO_out = {int_rq, 11'b0, int_addr};
      endcase
  end
endmodule

// File: tb/tb_int_controller.sv
// tb_int_controller: randomized and directed checks of int_controller against a behavioural model
module tb_int_controller;
  localparam int          N    = 8;
  localparam logic [15:0] BASE = 16'hFF00;
  localparam logic [15:0] CHM  = 16'h00FF;
  logic clk = 0, reset_n = 0;
  logic [N-1:0] irq_in = '0;
  logic [15:0] IO_address = BASE, data_in = '0;
  logic IO_wren = 0, IO_ren = 0, H_en = 0, L_en = 0;
  logic [15:0] IO_out;
  logic int_rq;
  logic [3:0] int_addr;
  int total = 0, bad = 0;
  logic [15:0] v;
  always #5 clk = ~clk;
  int_controller #(.NUM_CH(N), .IO_BASE(BASE)) dut (
    .clk(clk), .reset_n(reset_n), .irq_in(irq_in), .IO_address(IO_address),
    .data_in(data_in), .IO_wren(IO_wren), .IO_ren(IO_ren), .H_en(H_en), .L_en(L_en),
    .IO_out(IO_out), .int_rq(int_rq), .int_addr(int_addr)
  );
  // Behavioural model: sync pipeline, pending/mask/mode words, and a phase
  // (0 waiting, 1 in service, 2 mandatory low cycle after EOI)
  logic [15:0] m_s1, m_s2, m_prev, m_pend, m_mask, m_mode;
  logic [3:0]  m_addr;
  int          m_phase;
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic model_reset();
    m_s1 = 0; m_s2 = 0; m_prev = 0; m_pend = 0; m_mask = 0; m_mode = 0; m_addr = 0; m_phase = 0;
  endtask
  task automatic model_step();
    logic [15:0] off, rise, wm, clr, nxt;
    bit grant, hit;
    int gidx;
    if (!reset_n) begin
      model_reset();
      return;
    end
    off  = IO_address - BASE;
    hit  = off < 4;
    wm   = {{8{H_en}}, {8{L_en}}} & CHM;
    rise = m_s2 & ~m_prev;
    grant = 0;
    gidx  = 0;
    if (m_phase == 0)
      for (int c = N - 1; c >= 0; c--)
        if (m_pend[c] && m_mask[c]) begin grant = 1; gidx = c; end
    clr = (IO_wren && hit && off == 0) ? (data_in & wm) : 16'h0;
    nxt = 0;
    for (int c = 0; c < N; c++)
      nxt[c] = m_mode[c] ? ((m_pend[c] && !clr[c] && !(grant && gidx == c)) || rise[c]) : m_s2[c];
    if (IO_wren && hit && off == 1) m_mask = (m_mask & ~wm) | (data_in & wm);
    if (IO_wren && hit && off == 2) m_mode = (m_mode & ~wm) | (data_in & wm);
    if (m_phase == 0 && grant) m_phase = 1;
    else if (m_phase == 1 && IO_wren && hit && off == 3) m_phase = 2;
    else if (m_phase == 2) m_phase = 0;
    if (grant) m_addr = 4'(gidx);
    m_prev = m_s2;
    m_s2   = m_s1;
    m_s1   = 16'(irq_in);
    m_pend = nxt;
  endtask
  function automatic logic [15:0] exp_out();
    logic [15:0] off;
    off = IO_address - BASE;
    if (!reset_n || !IO_ren || off > 3) return 16'h0;
    case (off)
      16'd0:   return m_pend;
      16'd1:   return m_mask;
      16'd2:   return m_mode;
      default: return {m_phase == 1, 11'b0, m_addr};
    endcase
  endfunction
  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("int_rq", 16'(int_rq), 16'(m_phase == 1));
    chk("int_addr", 16'(int_addr), 16'(m_addr));
    chk("io_out", IO_out, exp_out());
  endtask
  task automatic rd(input logic [1:0] off, output logic [15:0] val);
    IO_ren = 1;
    IO_address = BASE + 16'(off);
    #1 val = IO_out;
    chk("rd_model", val, exp_out());
    IO_ren = 0;
  endtask
  task automatic wr(input logic [1:0] off, input logic [15:0] d, input logic h, input logic l);
    IO_wren = 1; IO_address = BASE + 16'(off); data_in = d; H_en = h; L_en = l;
    cycle();
    IO_wren = 0; H_en = 0; L_en = 0;
  endtask
  task automatic wait_rq(input int lim);
    int n = 0;
    while (!int_rq && n < lim) begin cycle(); n++; end
    chk("wait_rq", 16'(int_rq), 16'd1);
  endtask
  task automatic do_reset();
    reset_n = 0;
    model_reset();
    repeat (2) cycle();
    reset_n = 1;
  endtask
  initial begin
    model_reset();
    do_reset();
    rd(0, v); chk("rst_pend", v, 16'h0);
    rd(3, v); chk("rst_vec", v, 16'h0);
    // Latency of an enabled edge channel from an idle controller
    wr(1, 16'h0005, 1, 1);
    wr(2, 16'h0005, 1, 1);
    irq_in[2] = 1; cycle(); irq_in[2] = 0;
    cycle(); cycle();
    chk("lat_3cyc", 16'(int_rq), 16'd0);
    cycle();
    chk("lat_4cyc", 16'(int_rq), 16'd1);
    chk("lat_addr", 16'(int_addr), 16'd2);
    rd(0, v); chk("pend2_consumed", 16'(v[2]), 16'd0);
    wr(3, 16'hFFFF, 0, 0);
    chk("eoi_drop", 16'(int_rq), 16'd0);
    cycle();
    // Simultaneous edges: priority, then the gap before the second one
    irq_in = 8'h05; cycle(); irq_in = '0;
    wait_rq(10);
    chk("prio_first", 16'(int_addr), 16'd0);
    wr(3, 16'h0, 1, 1);
    chk("gap1", 16'(int_rq), 16'd0);
    cycle();
    chk("gap2", 16'(int_rq), 16'd0);
    cycle();
    chk("second_rq", 16'(int_rq), 16'd1);
    chk("second_addr", 16'(int_addr), 16'd2);
    wr(3, 16'h0, 1, 1); cycle();
    // Level channel re-requests after every EOI while held
    wr(1, 16'h0002, 1, 1);
    irq_in[1] = 1;
    wait_rq(10);
    chk("lvl_addr", 16'(int_addr), 16'd1);
    for (int k = 0; k < 3; k++) begin
      wr(3, 16'h0, 1, 1);
      chk("lvl_gap1", 16'(int_rq), 16'd0);
      cycle();
      chk("lvl_gap2", 16'(int_rq), 16'd0);
      cycle();
      chk("lvl_rerq", 16'(int_rq), 16'd1);
      chk("lvl_readdr", 16'(int_addr), 16'd1);
    end
    irq_in[1] = 0;
    repeat (4) cycle();
    rd(0, v); chk("lvl_pend_drop", v, 16'h0);
    wr(3, 16'h0, 1, 1);
    repeat (3) cycle();
    chk("lvl_quiet", 16'(int_rq), 16'd0);
    // Masked edge stays pending until the mask opens it (low byte only)
    wr(1, 16'h0005, 1, 1);
    wr(2, 16'h000D, 1, 1);
    irq_in[3] = 1; cycle(); irq_in[3] = 0;
    repeat (3) cycle();
    rd(0, v); chk("masked_pend3", 16'(v[3]), 16'd1);
    chk("masked_norq", 16'(int_rq), 16'd0);
    wr(1, 16'hFF08, 0, 1);
    rd(1, v); chk("mask_lowbyte", v, 16'h0008);
    wait_rq(5);
    chk("unmask_addr", 16'(int_addr), 16'd3);
    wr(3, 16'h0, 1, 1); cycle(); cycle();
    // A new edge wins over a same-cycle clear
    wr(1, 16'h0000, 1, 1);
    irq_in[2] = 1; cycle(); cycle();
    wr(0, 16'h0004, 1, 1);
    rd(0, v); chk("set_wins", 16'(v[2]), 16'd1);
    wr(0, 16'h0004, 1, 1);
    rd(0, v); chk("clear_after", 16'(v[2]), 16'd0);
    irq_in[2] = 0; cycle();
    // Reset while in service
    wr(1, 16'h0001, 1, 1);
    irq_in[0] = 1; cycle(); irq_in[0] = 0;
    wait_rq(8);
    #2 reset_n = 0;
    model_reset();
    IO_ren = 1; IO_address = BASE + 16'd3;
    #1 chk("rst_rq_async", 16'(int_rq), 16'd0);
    chk("rst_io", IO_out, 16'h0);
    IO_ren = 0;
    cycle();
    reset_n = 1;
    cycle();
    for (int k = 0; k < 4; k++) begin
      rd(2'(k), v);
      chk("post_rst_reg", v, 16'h0);
    end
    // Randomized traffic against the model
    do_reset();
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 3) == 0) irq_in ^= N'(1 << $urandom_range(0, N - 1));
      IO_wren    = $urandom_range(0, 3) == 0;
      IO_ren     = $urandom_range(0, 1) == 1;
      IO_address = BASE + 16'($urandom_range(0, 5)) - 16'd1;
      data_in    = 16'($urandom);
      H_en       = $urandom_range(0, 1) == 1;
      L_en       = $urandom_range(0, 3) != 0;
      cycle();
    end
    IO_wren = 0; IO_ren = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/int_controller.md
INT_CONTROLLER -- requirements
Module: int_controller

Interface
REQ-001 Parameter NUM_CH, default 8, number of interrupt sources; legal range 1..16.
REQ-002 Parameter IO_BASE, default 16'hFF00, IO word address of register 0; registers at IO_BASE+0..+3.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 reset_n  input  1  asynchronous active-low reset.
REQ-005 irq_in  input  NUM_CH  interrupt sources, same clock domain, bit 0 highest priority.
REQ-006 IO_address  input  16  CPU IO address.
REQ-007 data_in  input  16  CPU write data.
REQ-008 IO_wren  input  1  IO write strobe, one cycle per write.
REQ-009 IO_ren  input  1  IO read enable.
REQ-010 H_en  input  1  write enable, bits 15:8.
REQ-011 L_en  input  1  write enable, bits 7:0.
REQ-012 IO_out  output  16  read data; combinational.
REQ-013 int_rq  output  1  interrupt request to CPU; registered.
REQ-014 int_addr  output  4  vector of the in-service channel; registered.

Function
REQ-015 irq_in SHALL pass a 2-flop synchronizer; the second stage is "irq_s". The previous irq_s value is kept for edge detection.
REQ-016 Registers: 0 PEND, 1 MASK (RW, 1=enabled), 2 MODE (RW, 1=edge, 0=level), 3 VEC.
REQ-017 Edge channel: a rising edge on irq_s SHALL set PEND.
REQ-018 Edge channel: writing 1 to a PEND bit SHALL clear it.
REQ-019 Edge channel: set SHALL win over a same-cycle clear.
REQ-020 Level channel: PEND SHALL equal irq_s every cycle; PEND writes have no effect.
REQ-021 Register bits at index >= NUM_CH SHALL read 0 and ignore writes.
REQ-022 Writes SHALL occur only when IO_wren=1 and the address matches.
REQ-023 Writes SHALL update bits 15:8 only if H_en=1, and bits 7:0 only if L_en=1.
REQ-024 IO_out SHALL be the addressed register when IO_ren=1 and the address matches; otherwise 16'h0000, same cycle (no wait state).
REQ-025 VEC read SHALL be {int_rq, 11'b0, int_addr}.
REQ-026 Any write to VEC SHALL be an EOI; data is ignored.
REQ-027 FSM states: IDLE, ACTIVE, GAP.
REQ-028 IDLE: if (PEND & MASK) != 0, the FSM SHALL go to ACTIVE next cycle.
REQ-029 On entering ACTIVE, the FSM SHALL latch int_addr = lowest set index of PEND&MASK and set int_rq=1. If that channel is edge-mode, its PEND SHALL clear in the same cycle.
REQ-030 ACTIVE: int_rq and int_addr SHALL hold until EOI. PEND, MASK and MODE changes SHALL NOT alter them.
REQ-031 ACTIVE + EOI: the FSM SHALL go to GAP and clear int_rq.
REQ-032 GAP: the FSM SHALL go to IDLE unconditionally; int_rq is 0 for at least 2 cycles, so the CPU sees a fresh rising edge.
REQ-033 EOI in IDLE or GAP SHALL be ignored.
REQ-034 Latency: irq_in rise -> int_rq=1 SHALL take 4 cycles (2 sync, 1 PEND, 1 FSM) when the channel is enabled and the FSM is IDLE.
REQ-035 Level channel still asserted after EOI SHALL be re-requested via IDLE -> ACTIVE.

Reset
REQ-036 While reset_n=0, state SHALL clear asynchronously: PEND=0, MASK=0, MODE=0, synchronizers=0, edge history=0, FSM=IDLE, int_rq=0, int_addr=0.
REQ-037 Reset during ACTIVE SHALL drop int_rq immediately, with no EOI required.
REQ-038 IO_out SHALL be 0 during reset.

Structure
REQ-039 A shared package SHALL hold the register offsets (PEND, MASK, MODE, VEC), the FSM state encoding, and the NUM_CH upper bound 16.
REQ-040 A sub-module prio_enc SHALL be parameterised by NUM_CH. It outputs the 4-bit lowest-index and an any-set flag.

Verification
REQ-041 NUM_CH=8. MASK=0x0005, MODE=0x0005; pulse irq_in[2] high 1 cycle -> int_rq=1 exactly 4 cycles later, int_addr=2, PEND[2]=0.
REQ-042 irq_in[0] and irq_in[2] rise together, both enabled edge -> first int_addr=0. EOI -> int_rq low 2 cycles, then int_addr=2.
REQ-043 Level channel 1 held high, MASK[1]=1, MODE[1]=0. Repeated EOIs -> int_rq re-asserts each time with int_addr=1. After irq_in[1] drops plus 3 cycles, PEND=0 and int_rq stays 0.
REQ-044 Edge on ch3 with MASK[3]=0 -> PEND[3]=1, int_rq=0. Write MASK with H_en=0, L_en=1, data 0x0008 -> request with int_addr=3.
REQ-045 Write 0x0004 to PEND in the same cycle as a new irq_s[2] edge -> PEND[2] remains 1.
REQ-046 int_rq=1, then reset_n low mid-ACTIVE -> int_rq=0 and all registers read 0 after release.
